apb_ram_param: RTL and testbench

Parametrised APB slave RAM. It is the successor to the team's fixed 8-bit × 16 APB RAM, generalised in data width, depth and wait-state count, and adds byte strobes, a read-only low region and abort handling. It sits on the peripheral APB bus as a scratch/config memory. Word-addressed: paddr is the word index.

---
 rtl/apb_ram_param.sv | 118 +++++++++++
 tb/tb_apb_ram_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_param.sv
// Parametrised APB slave RAM: byte strobes, wait states, read-only low region.
// Memory holds its contents through reset; only the handshake logic is reset.
module apb_ram_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for the full paddr and for DEPTH/RO_WORDS, so no bits are dropped.
    localparam int CMP_W  = (ADDR_W > 33) ? ADDR_W : 33;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;

    logic [CMP_W-1:0]    w_addr_ext;
    logic                w_addr_err;
    logic                w_ro_err;
    logic                w_err;
    logic                w_done;
    logic                w_wr_en;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rdata;

    assign w_addr_ext = CMP_W'(paddr);
    assign w_addr_err = (w_addr_ext >= CMP_W'(DEPTH));
    assign w_ro_err   = pwrite && (w_addr_ext < CMP_W'(RO_WORDS));
    assign w_err      = w_addr_err || w_ro_err;
    assign w_done     = (r_state == S_ACCESS) && psel && penable && (r_cnt == 4'd0);
    assign w_wr_en    = w_done && pwrite && !w_err;
    assign w_idx      = IDX_W'(paddr);

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        pready       = 1'b0;
        pslverr      = 1'b0;
        prdata       = '0;
        case (r_state)
            S_IDLE: begin
                // An access phase without a preceding setup phase is ignored.
                if (psel && !penable) begin
                    w_state_next = S_ACCESS;
                    w_cnt_next   = WAIT_LD;
                end
            end
            S_ACCESS: begin
                if (!psel) begin
                    w_state_next = S_IDLE;
                end else if (penable) begin
                    if (r_cnt == 4'd0) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        pready  = w_done;
        pslverr = w_done && w_err;
        if (w_done && !pwrite && !w_err) begin
            prdata = w_rdata;
        end
    end

    // One byte-wide array per lane keeps each strobe's write port independent.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH];

            always_ff @(posedge pclk) begin
                if (w_wr_en && pstrb[gi]) begin
                    r_lane[w_idx] <= pwdata[gi*8 +: 8];
                end
            end

            assign w_rdata[gi*8 +: 8] = r_lane[w_idx];
        end
    endgenerate

    a_err_qualified: assert property (@(posedge pclk) disable iff (!prst) (pslverr |-> pready));

endmodule

// File: tb/tb_apb_ram_param.sv
// Randomised bench for apb_ram_param: driver pushes predicted responses,
// a negedge monitor pops and compares them whenever pready is seen.
module tb_apb_ram_param;

    localparam int DW    = 32;
    localparam int AW    = 40;
    localparam int DEPTH = 64;
    localparam int WS    = 3;
    localparam int RO    = 4;

    logic          clk;
    logic          prst;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [31:0] mask;
        logic [39:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem   [DEPTH];
    logic [3:0]  ref_known [DEPTH];

    apb_ram_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS), .RO_WORDS(RO)
    ) dut (
        .pclk(clk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: apply the transfer's architectural effect and predict its response.
    function automatic void model(input logic wr, input logic [39:0] a,
                                  input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   idx;
        e.addr = a;
        e.err  = (a >= 40'(DEPTH)) || (wr && (a < 40'(RO)));
        e.data = 32'h0;
        e.mask = 32'hFFFF_FFFF;
        if (!e.err) begin
            idx = int'(a[5:0]);
            if (wr) begin
                e.mask = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) begin
                        ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                        ref_known[idx][b]      = 1'b1;
                    end
                end
            end else begin
                e.data = ref_mem[idx];
                for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{ref_known[idx][b]}};
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic xfer(input logic wr, input logic [39:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int cyc;
        model(wr, a, d, s);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        @(negedge clk);
        while (!pready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != WS + 1 || !pready) begin
            failures++;
            $display("FAIL latency addr=%0h got=%0d cycles required=%0d", a, cyc, WS + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (pready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pready addr=%0h prdata=%h pslverr=%b", paddr, prdata, pslverr);
            end else begin
                mon_e = exp_q.pop_front();
                if (pslverr !== mon_e.err || (prdata & mon_e.mask) !== (mon_e.data & mon_e.mask)) begin
                    failures++;
                    $display("FAIL response addr=%0h got prdata=%h pslverr=%b required prdata=%h mask=%h pslverr=%b",
                             mon_e.addr, prdata, pslverr, mon_e.data, mon_e.mask, mon_e.err);
                end else begin
                    $display("txn addr=%0h wr=%b prdata=%h pslverr=%b", mon_e.addr, pwrite, prdata, pslverr);
                end
            end
        end else begin
            checks++;
            if (prdata !== 32'h0 || pslverr !== 1'b0) begin
                failures++;
                $display("FAIL idle_outputs got prdata=%h pslverr=%b required 0/0", prdata, pslverr);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] a;
        logic        wr;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = 32'h0;
            ref_known[i] = 4'h0;
        end
        prst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got pready=%b pslverr=%b prdata=%h required 0/0/0", pready, pslverr, prdata);
        end
        prst = 1'b1;
        idle(2);

        // Directed transfers following the test plan.
        xfer(1'b1, 40'd5, 32'hA5A5_1234, 4'hF);
        xfer(1'b0, 40'd5, 32'h0, 4'h0);
        idle(1);
        xfer(1'b1, 40'd5, 32'hFFFF_FFFF, 4'b0101);
        xfer(1'b0, 40'd5, 32'h0, 4'h0);
        xfer(1'b1, 40'd63, 32'h6363_6363, 4'hF);
        xfer(1'b1, 40'd64, 32'hBAD0_0001, 4'hF);
        xfer(1'b1, 40'h1_0000_0000, 32'hBAD0_0002, 4'hF);
        xfer(1'b0, 40'd63, 32'h0, 4'h0);
        xfer(1'b0, 40'd64, 32'h0, 4'h0);
        xfer(1'b1, 40'd2, 32'h2222_2222, 4'hF);
        xfer(1'b0, 40'd2, 32'h0, 4'h0);
        xfer(1'b1, 40'd5, 32'h0BAD_0BAD, 4'h0);
        xfer(1'b0, 40'd5, 32'h0, 4'h0);
        idle(1);

        // Abort: psel dropped after one access cycle, memory must not change.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 40'd5; pwdata = 32'hDEAD_DEAD; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        idle(3);
        xfer(1'b0, 40'd5, 32'h0, 4'h0);

        // Reset pulsed in the completion cycle of a write: dropped, outputs cleared at once.
        xfer(1'b1, 40'd10, 32'h1122_3344, 4'hF);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 40'd10; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (WS) @(posedge clk);
        #1;
        checks++;
        if (pready !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_pready got=%b required=1", pready);
        end
        prst = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_access got pready=%b pslverr=%b prdata=%h required 0/0/0", pready, pslverr, prdata);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; prst = 1'b1;
        xfer(1'b0, 40'd10, 32'h0, 4'h0);
        idle(1);

        // Randomised traffic, biased to a small address pool so reads hit written words.
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 40'($urandom_range(0, 15));
                4, 5, 6:    a = 40'($urandom_range(0, DEPTH - 1));
                7:          a = 40'(DEPTH) + 40'($urandom_range(0, 3));
                8:          a = 40'h1_0000_0000 + 40'($urandom_range(0, 63));
                default:    a = 40'($urandom_range(0, RO - 1));
            endcase
            wr = 1'($urandom_range(0, 1));
            xfer(wr, a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_responses got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
